// File: rtl/eq_pkg.sv
// ---------------------------------------------------------------------------
// eq_pkg
// Shared definitions for the equalizer blocks: default sample width, gain
// fraction bits, band count, the band-combiner FSM state encoding, and a
// helper that sizes the MAC accumulator.
// No ports (package).
// ---------------------------------------------------------------------------
package eq_pkg;

   localparam int EQ_NBANDS    = 8;
   localparam int EQ_DATA_W    = 16;
   localparam int EQ_GAIN_FRAC = 12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_HOLD = 2'd2
   } eq_state_e;

   // Full product width plus enough guard bits to sum NBANDS worst-case
   // products without overflow.
   function automatic int acc_width(input int data_w, input int nbands);
      return 2 * data_w + $clog2(nbands);
   endfunction

endpackage

// File: rtl/eq_mac_sat.sv
// ---------------------------------------------------------------------------
// eq_mac_sat
// Multiply-accumulate datapath with round-half-up and saturation. One signed
// DATA_W x DATA_W multiplier is shared across all bands; the controller
// presents one band/gain pair per cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         clear the accumulator (start of a new sample set)
//   mac_en      accumulate a*b this cycle
//   fin         last product of the set: round, saturate and register y/sat
//   a, b        signed band sample and Q4.12 gain for the current band
//   y, sat      registered result and clip flag (held until the next fin)
// ---------------------------------------------------------------------------
module eq_mac_sat
   import eq_pkg::*;
#(
   parameter int NBANDS    = EQ_NBANDS,
   parameter int DATA_W    = EQ_DATA_W,
   parameter int GAIN_FRAC = EQ_GAIN_FRAC
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     mac_en,
   input  logic                     fin,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [DATA_W-1:0] y,
   output logic                     sat
);

   localparam int ACC_W  = acc_width(DATA_W, NBANDS);
   localparam int PROD_W = 2 * DATA_W;

   localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (GAIN_FRAC - 1);
   localparam logic signed [ACC_W-1:0] Y_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
   // Two's complement: ~MAX == -MAX-1 == most negative DATA_W value.
   localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [DATA_W-1:0] y_q, y_d;
   logic                     sat_q, sat_d;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  rnd;
   logic signed [ACC_W-1:0]  shifted;

   // Operands are sign-extended to the product width so the multiply is
   // evaluated fully signed at 2*DATA_W bits.
   assign prod     = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
   assign prod_ext = ACC_W'(prod);
   assign sum      = acc_q + prod_ext;
   assign rnd      = sum + HALF;
   assign shifted  = rnd >>> GAIN_FRAC;

   always_comb begin
      acc_d = acc_q;
      y_d   = y_q;
      sat_d = sat_q;
      if (clr) begin
         acc_d = '0;
      end else if (mac_en) begin
         acc_d = sum;
         // The final product goes straight into the rounding path so the
         // result is registered on the same edge as the last accumulation.
         if (fin) begin
            if (shifted > Y_MAX) begin
               y_d   = Y_MAX[DATA_W-1:0];
               sat_d = 1'b1;
            end else if (shifted < Y_MIN) begin
               y_d   = Y_MIN[DATA_W-1:0];
               sat_d = 1'b1;
            end else begin
               y_d   = shifted[DATA_W-1:0];
               sat_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         y_q   <= '0;
         sat_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         y_q   <= y_d;
         sat_q <= sat_d;
      end
   end

   assign y   = y_q;
   assign sat = sat_q;

endmodule

// File: rtl/eq_band_combiner.sv
// ---------------------------------------------------------------------------
// eq_band_combiner
// Combines NBANDS equalizer band outputs into one sample:
//   y = sat(round(sum band[k]*g[k]) >> GAIN_FRAC)
// A sample set is captured on accept, then one band is multiplied and
// accumulated per cycle through eq_mac_sat; the result is held until taken.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in HOLD, so the
// two are never high together. Once out_valid rises, y/sat/out_valid stay
// unchanged until out_ready is seen; out_ready while out_valid is low has no
// effect. Inputs are only looked at in the IDLE accept cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   band[NBANDS]         signed per-band samples (DATA_W each)
//   g[NBANDS]            signed per-band gains, Q4.12 (DATA_W each)
//   in_valid / in_ready  input sample-set handshake
//   y, sat               combined saturated sample and clip flag
//   out_valid/out_ready  output handshake
// ---------------------------------------------------------------------------
module eq_band_combiner
   import eq_pkg::*;
#(
   parameter int NBANDS    = EQ_NBANDS,
   parameter int DATA_W    = EQ_DATA_W,
   parameter int GAIN_FRAC = EQ_GAIN_FRAC
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NBANDS-1:0][DATA_W-1:0]  band,
   input  logic [NBANDS-1:0][DATA_W-1:0]  g,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic signed [DATA_W-1:0]       y,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           sat
);

   localparam int               IDX_W    = (NBANDS > 1) ? $clog2(NBANDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBANDS - 1);

   eq_state_e                      state_q, state_d;
   logic [IDX_W-1:0]               idx_q, idx_d;
   logic [NBANDS-1:0][DATA_W-1:0]  band_q, band_d;
   logic [NBANDS-1:0][DATA_W-1:0]  g_q, g_d;

   logic clr;
   logic mac_en;
   logic fin;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      band_d    = band_q;
      g_d       = g_q;
      clr       = 1'b0;
      mac_en    = 1'b0;
      fin       = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               band_d  = band;
               g_d     = g;
               idx_d   = '0;
               clr     = 1'b1;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            mac_en = 1'b1;
            if (idx_q == LAST_IDX) begin
               fin     = 1'b1;
               idx_d   = '0;
               state_d = ST_HOLD;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         band_q  <= '0;
         g_q     <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         band_q  <= band_d;
         g_q     <= g_d;
      end
   end

   eq_mac_sat #(
      .NBANDS    (NBANDS),
      .DATA_W    (DATA_W),
      .GAIN_FRAC (GAIN_FRAC)
   ) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .mac_en (mac_en),
      .fin    (fin),
      .a      (band_q[idx_q]),
      .b      (g_q[idx_q]),
      .y      (y),
      .sat    (sat)
   );

endmodule
